// File: rtl/axis_frame_gen_pkg.sv
// Shared types and helpers for the AXI4-Stream frame generator.
package axis_frame_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_e;

    localparam int unsigned MAX_KEEP = 64;

    // Last-beat byte enables: low 'rem' lanes set, or every lane when the length is a whole beat multiple.
    function automatic logic [MAX_KEEP-1:0] last_keep(input int unsigned rem, input int unsigned keep_w);
        logic [MAX_KEEP-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_KEEP; i++) begin
            if ((i < keep_w) && ((rem == 0) || (i < rem))) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/axis_frame_gen_if.sv
// AXI4-Stream bundle carrying tdata/tkeep/tvalid/tready/tlast/tuser.
interface axis_frame_gen_if #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (
        output tdata, tkeep, tvalid, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/axis_frame_gen_pattern.sv
// Byte pattern for one beat: lane k = frame_index + byte_offset + k (mod 256), disabled lanes forced to zero.
module axis_frame_gen_pattern #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic [7:0]            frame_index_i,
    input  logic [7:0]            byte_offset_i,
    input  logic [KEEP_WIDTH-1:0] tkeep_i,
    output logic [DATA_WIDTH-1:0] tdata_o
);
    always_comb begin
        tdata_o = '0;
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            if (tkeep_i[k]) begin
                tdata_o[8*k +: 8] = frame_index_i + byte_offset_i + 8'(k);
            end
        end
    end
endmodule

// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame source: programmed frame count/length/gap with a deterministic byte pattern.
// Define AXIS_FRAME_GEN_ERR_INJECT_EN to mark every err_period-th frame bad via tuser.
module axis_frame_gen
    import axis_frame_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [LEN_WIDTH-1:0] frame_len,
    input  logic [LEN_WIDTH-1:0] frame_count,
    input  logic [7:0]           gap_cycles,
    input  logic [7:0]           err_period,
    axis_frame_gen_if.master     m_axis,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] frames_sent
);
    state_e                 state_q;
    logic [LEN_WIDTH-1:0]   len_q, count_q, run_cnt_q, off_q;
    logic [7:0]             gap_q, gap_cnt_q, frame_idx_q;
    logic [CNT_WIDTH-1:0]   frames_sent_q;
    logic                   busy_q, done_q;
    logic [DATA_WIDTH-1:0]  tdata_q;
    logic [KEEP_WIDTH-1:0]  tkeep_q;
    logic                   tvalid_q, tlast_q, tuser_q;

    logic [LEN_WIDTH-1:0]   len_in_eff, sel_len, sel_off;
    logic [7:0]             sel_idx;
    logic                   sel_bad, beat_last, beat_user, beat_acc, frame_end, run_done;
    logic [KEEP_WIDTH-1:0]  beat_keep;
    logic [DATA_WIDTH-1:0]  beat_data;

    assign len_in_eff = (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;
    assign beat_acc   = (state_q == SEND) && tvalid_q && m_axis.tready;
    assign frame_end  = beat_acc && tlast_q;
    assign run_done   = stop || ((count_q != '0) && ((run_cnt_q + LEN_WIDTH'(1)) == count_q));

    // Select the beat that will be loaded into the output registers on this edge.
    always_comb begin
        sel_idx = frame_idx_q;
        sel_off = '0;
        sel_len = len_q;
        case (state_q)
            IDLE: begin
                sel_idx = '0;
                sel_len = len_in_eff;
            end
            SEND: begin
                if (frame_end) begin
                    sel_idx = frame_idx_q + 8'd1;
                end else begin
                    sel_off = off_q + LEN_WIDTH'(KEEP_WIDTH);
                end
            end
            default: ;
        endcase
    end

    assign beat_last = ({1'b0, sel_off} + (LEN_WIDTH+1)'(KEEP_WIDTH)) >= {1'b0, sel_len};
    assign beat_keep = beat_last ? KEEP_WIDTH'(last_keep(32'(sel_len) % KEEP_WIDTH, KEEP_WIDTH)) : '1;
    assign beat_user = beat_last && sel_bad;

    axis_frame_gen_pattern #(
        .DATA_WIDTH(DATA_WIDTH),
        .KEEP_WIDTH(KEEP_WIDTH)
    ) u_pattern (
        .frame_index_i(sel_idx),
        .byte_offset_i(sel_off[7:0]),
        .tkeep_i      (beat_keep),
        .tdata_o      (beat_data)
    );

`ifdef AXIS_FRAME_GEN_ERR_INJECT_EN
    logic [7:0] err_period_q, err_cnt_q, err_cnt_nxt;

    // Down-counter reaching 1 marks the current frame as bad, then reloads.
    assign err_cnt_nxt = (err_cnt_q == 8'd1) ? err_period_q : err_cnt_q - 8'd1;

    always_comb begin
        sel_bad = (err_period_q != 8'd0) && (err_cnt_q == 8'd1);
        if (state_q == IDLE) begin
            sel_bad = (err_period == 8'd1);
        end else if (frame_end) begin
            sel_bad = (err_period_q != 8'd0) && (err_cnt_nxt == 8'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_period_q <= '0;
            err_cnt_q    <= '0;
        end else if ((state_q == IDLE) && start) begin
            err_period_q <= err_period;
            err_cnt_q    <= err_period;
        end else if (frame_end) begin
            err_cnt_q    <= err_cnt_nxt;
        end
    end
`else
    logic unused_err_period;
    assign unused_err_period = ^err_period;
    assign sel_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            len_q         <= '0;
            count_q       <= '0;
            run_cnt_q     <= '0;
            off_q         <= '0;
            gap_q         <= '0;
            gap_cnt_q     <= '0;
            frame_idx_q   <= '0;
            frames_sent_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            tdata_q       <= '0;
            tkeep_q       <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            tuser_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q         <= len_in_eff;
                        count_q       <= frame_count;
                        gap_q         <= gap_cycles;
                        run_cnt_q     <= '0;
                        off_q         <= '0;
                        frame_idx_q   <= '0;
                        frames_sent_q <= '0;
                        busy_q        <= 1'b1;
                        tvalid_q      <= 1'b1;
                        tdata_q       <= beat_data;
                        tkeep_q       <= beat_keep;
                        tlast_q       <= beat_last;
                        tuser_q       <= beat_user;
                        state_q       <= SEND;
                    end
                end
                SEND: begin
                    if (frame_end) begin
                        frames_sent_q <= frames_sent_q + CNT_WIDTH'(1);
                        frame_idx_q   <= frame_idx_q + 8'd1;
                        run_cnt_q     <= run_cnt_q + LEN_WIDTH'(1);
                        off_q         <= '0;
                        if (run_done || (gap_q != 8'd0)) begin
                            tvalid_q <= 1'b0;
                            tdata_q  <= '0;
                            tkeep_q  <= '0;
                            tlast_q  <= 1'b0;
                            tuser_q  <= 1'b0;
                        end else begin
                            tdata_q  <= beat_data;
                            tkeep_q  <= beat_keep;
                            tlast_q  <= beat_last;
                            tuser_q  <= beat_user;
                        end
                        if (run_done) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else if (gap_q != 8'd0) begin
                            gap_cnt_q <= gap_q;
                            state_q   <= GAP;
                        end
                    end else if (beat_acc) begin
                        off_q   <= sel_off;
                        tdata_q <= beat_data;
                        tkeep_q <= beat_keep;
                        tlast_q <= beat_last;
                        tuser_q <= beat_user;
                    end
                end
                GAP: begin
                    if (stop) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (gap_cnt_q == 8'd1) begin
                        tvalid_q <= 1'b1;
                        tdata_q  <= beat_data;
                        tkeep_q  <= beat_keep;
                        tlast_q  <= beat_last;
                        tuser_q  <= beat_user;
                        state_q  <= SEND;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tuser  = tuser_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign frames_sent   = frames_sent_q;
endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed bench for axis_frame_gen with DATA_WIDTH=32.
module tb_axis_frame_gen;
    logic        clk = 1'b0;
    logic        rst, start, stop, tready;
    logic [15:0] frame_len, frame_count;
    logic [7:0]  gap_cycles, err_period;
    logic        busy, done;
    logic [31:0] frames_sent;

    logic [31:0] q_data[$];
    logic [3:0]  q_keep[$];
    bit          q_last[$];
    bit          q_user[$];
    bit          q_valid[$];
    int          stall_err;
    bit          timed_out;
    int          total = 0;
    int          bad = 0;

    axis_frame_gen_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4)) m_axis ();
    assign m_axis.tready = tready;

    axis_frame_gen #(
        .DATA_WIDTH(32),
        .KEEP_WIDTH(4),
        .LEN_WIDTH (16),
        .CNT_WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .frame_len  (frame_len),
        .frame_count(frame_count),
        .gap_cycles (gap_cycles),
        .err_period (err_period),
        .m_axis     (m_axis),
        .busy       (busy),
        .done       (done),
        .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int len, input int cnt, input int gap, input int per);
        frame_len   = 16'(len);
        frame_count = 16'(cnt);
        gap_cycles  = 8'(gap);
        err_period  = 8'(per);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs until done, recording accepted beats and per-cycle tvalid; flags changes while stalled.
    task automatic collect(input int max_cyc, input int rdy_pct, input int stop_at, input bit stop_in_gap);
        logic [31:0] pd;
        logic [3:0]  pk;
        bit          pl, pu, prev_stall;
        q_data.delete(); q_keep.delete(); q_last.delete(); q_user.delete(); q_valid.delete();
        stall_err = 0;
        timed_out = 1'b0;
        prev_stall = 1'b0;
        pd = '0; pk = '0; pl = 1'b0; pu = 1'b0;
        for (int c = 0; ; c++) begin
            if (done === 1'b1) break;
            if (c >= max_cyc) begin
                timed_out = 1'b1;
                break;
            end
            if (prev_stall && (m_axis.tvalid !== 1'b1 || m_axis.tdata !== pd || m_axis.tkeep !== pk ||
                               m_axis.tlast !== pl || m_axis.tuser !== pu))
                stall_err++;
            if (stop_at >= 0 && frames_sent == 32'(stop_at) &&
                (stop_in_gap ? (m_axis.tvalid === 1'b0) : (m_axis.tvalid === 1'b1 && m_axis.tlast === 1'b0)))
                stop = 1'b1;
            tready = (rdy_pct >= 100) || ($urandom_range(99) < rdy_pct);
            q_valid.push_back(m_axis.tvalid);
            if (m_axis.tvalid && tready) begin
                q_data.push_back(m_axis.tdata);
                q_keep.push_back(m_axis.tkeep);
                q_last.push_back(m_axis.tlast);
                q_user.push_back(m_axis.tuser);
            end
            prev_stall = m_axis.tvalid && !tready;
            pd = m_axis.tdata; pk = m_axis.tkeep; pl = m_axis.tlast; pu = m_axis.tuser;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        total++;
        if (m_axis.tvalid !== 1'b0 || m_axis.tdata !== 32'h0 || m_axis.tkeep !== 4'h0 ||
            m_axis.tlast !== 1'b0 || m_axis.tuser !== 1'b0) begin
            bad++;
            $display("FAIL reset_stream got v=%b d=%h k=%h l=%b u=%b exp all zero",
                     m_axis.tvalid, m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tuser);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || frames_sent !== 32'd0) begin
            bad++;
            $display("FAIL reset_status got busy=%b done=%b sent=%0d exp 0 0 0", busy, done, frames_sent);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [31:0] exp_d [3] = '{32'h03020100, 32'h07060504, 32'h00000908};
        logic [3:0]  exp_k [3] = '{4'hF, 4'hF, 4'h3};
        bit          exp_l [3] = '{1'b0, 1'b0, 1'b1};
        pulse_start(10, 1, 0, 0);
        total++;
        if (m_axis.tvalid !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_latency got valid=%b busy=%b exp 1 1", m_axis.tvalid, busy);
        end
        collect(50, 100, -1, 1'b0);
        total++;
        if (timed_out || q_data.size() != 3) begin
            bad++;
            $display("FAIL single_beats got n=%0d timeout=%b exp n=3", q_data.size(), timed_out);
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (q_data[i] !== exp_d[i] || q_keep[i] !== exp_k[i] || q_last[i] !== exp_l[i]) begin
                    bad++;
                    $display("FAIL single_beat[%0d] got d=%h k=%h l=%b exp d=%h k=%h l=%b",
                             i, q_data[i], q_keep[i], q_last[i], exp_d[i], exp_k[i], exp_l[i]);
                end
            end
        end
        total++;
        if (busy !== 1'b0 || frames_sent !== 32'd1) begin
            bad++;
            $display("FAIL single_done got busy=%b sent=%0d exp 0 1", busy, frames_sent);
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL single_done_width got done=%b exp 0", done);
        end
    endtask

    task automatic test_len_zero();
        pulse_start(0, 1, 0, 0);
        collect(20, 100, -1, 1'b0);
        total++;
        if (q_data.size() != 1 || q_data[0] !== 32'h0 || q_keep[0] !== 4'h1 || q_last[0] !== 1'b1) begin
            bad++;
            $display("FAIL len_zero got n=%0d d=%h k=%h l=%b exp n=1 d=0 k=1 l=1",
                     q_data.size(), q_data[0], q_keep[0], q_last[0]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [6] = '{32'h03020100, 32'h07060504, 32'h04030201,
                                   32'h08070605, 32'h05040302, 32'h09080706};
        int lows;
        pulse_start(8, 3, 0, 0);
        collect(50, 100, -1, 1'b0);
        lows = 0;
        foreach (q_valid[i]) if (!q_valid[i]) lows++;
        total++;
        if (q_valid.size() != 6 || lows != 0) begin
            bad++;
            $display("FAIL b2b_valid got cycles=%0d low=%0d exp 6 0", q_valid.size(), lows);
        end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (q_data[i] !== exp_d[i] || q_last[i] !== (i % 2 == 1)) begin
                bad++;
                $display("FAIL b2b_beat[%0d] got d=%h l=%b exp d=%h l=%b", i, q_data[i], q_last[i],
                         exp_d[i], (i % 2 == 1));
            end
        end
        total++;
        if (frames_sent !== 32'd3 || timed_out) begin
            bad++;
            $display("FAIL b2b_sent got %0d timeout=%b exp 3", frames_sent, timed_out);
        end
        tick();
    endtask

    task automatic test_gap();
        int lows;
        pulse_start(4, 2, 5, 0);
        collect(50, 100, -1, 1'b0);
        lows = 0;
        foreach (q_valid[i]) if (!q_valid[i]) lows++;
        total++;
        if (lows != 5 || q_valid.size() != 7) begin
            bad++;
            $display("FAIL gap_low got low=%0d cycles=%0d exp 5 7", lows, q_valid.size());
        end
        total++;
        if (q_data.size() != 2 || q_data[1] !== 32'h04030201) begin
            bad++;
            $display("FAIL gap_frame1 got n=%0d d=%h exp 2 04030201", q_data.size(), q_data[1]);
        end
        tick();
    endtask

    task automatic test_stall();
        logic [31:0] exp_d [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0000000C};
        logic [3:0]  exp_k [4] = '{4'hF, 4'hF, 4'hF, 4'h1};
        pulse_start(13, 1, 0, 0);
        collect(300, 50, -1, 1'b0);
        total++;
        if (stall_err != 0 || timed_out) begin
            bad++;
            $display("FAIL stall_stable got changes=%0d timeout=%b exp 0", stall_err, timed_out);
        end
        total++;
        if (q_data.size() != 4) begin
            bad++;
            $display("FAIL stall_beats got n=%0d exp 4", q_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (q_data[i] !== exp_d[i] || q_keep[i] !== exp_k[i] || q_last[i] !== (i == 3)) begin
                    bad++;
                    $display("FAIL stall_beat[%0d] got d=%h k=%h l=%b exp d=%h k=%h", i, q_data[i],
                             q_keep[i], q_last[i], exp_d[i], exp_k[i]);
                end
            end
        end
        tick();
    endtask

    task automatic test_stop();
        int lasts;
        pulse_start(8, 0, 0, 0);
        collect(100, 100, 4, 1'b0);
        stop = 1'b0;
        lasts = 0;
        foreach (q_last[i]) if (q_last[i]) lasts++;
        total++;
        if (timed_out || frames_sent !== 32'd5 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stop_sent got sent=%0d busy=%b timeout=%b exp 5 0", frames_sent, busy, timed_out);
        end
        total++;
        if (q_data.size() != 10 || lasts != 5 || q_last[9] !== 1'b1 || q_data[9] !== 32'h0B0A0908) begin
            bad++;
            $display("FAIL stop_frame got n=%0d lasts=%0d d9=%h exp 10 5 0b0a0908", q_data.size(), lasts, q_data[9]);
        end
        tick();
        pulse_start(4, 0, 3, 0);
        collect(100, 100, 1, 1'b1);
        stop = 1'b0;
        total++;
        if (timed_out || frames_sent !== 32'd1 || q_data.size() != 1) begin
            bad++;
            $display("FAIL stop_gap got sent=%0d n=%0d timeout=%b exp 1 1", frames_sent, q_data.size(), timed_out);
        end
        tick();
    endtask

    task automatic test_err_inject();
        bit exp_u;
        pulse_start(6, 4, 1, 2);
        collect(100, 100, -1, 1'b0);
        total++;
        if (q_data.size() != 8 || q_data[1] !== 32'h00000504 || q_keep[1] !== 4'h3 || q_data[6] !== 32'h06050403) begin
            bad++;
            $display("FAIL err_beats got n=%0d d1=%h k1=%h d6=%h exp 8 00000504 3 06050403",
                     q_data.size(), q_data[1], q_keep[1], q_data[6]);
        end
        for (int i = 0; i < 8; i++) begin
`ifdef AXIS_FRAME_GEN_ERR_INJECT_EN
            exp_u = (i == 3) || (i == 7);
`else
            exp_u = 1'b0;
`endif
            total++;
            if (q_user[i] !== exp_u) begin
                bad++;
                $display("FAIL err_tuser[%0d] got %b exp %b", i, q_user[i], exp_u);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        pulse_start(4, 0, 0, 0);
        tready = 1'b1;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        total++;
        if (m_axis.tvalid !== 1'b0 || busy !== 1'b0 || frames_sent !== 32'd0 || m_axis.tlast !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got valid=%b busy=%b sent=%0d last=%b exp 0 0 0 0",
                     m_axis.tvalid, busy, frames_sent, m_axis.tlast);
        end
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (m_axis.tvalid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_idle got valid=%b busy=%b exp 0 0", m_axis.tvalid, busy);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; tready = 1'b0;
        frame_len = '0; frame_count = '0; gap_cycles = '0; err_period = '0;
        test_reset();
        test_single();
        test_len_zero();
        test_back_to_back();
        test_gap();
        test_stall();
        test_stop();
        test_err_inject();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_frame_gen.md
# axis_frame_gen

AXI4-Stream frame source: on command, transmits a programmed number of frames of programmed byte length onto an AXI4-Stream master port, with a deterministic byte pattern, correct tkeep on the final beat, tlast, and a configurable inter-frame gap. It drives the slave input of the stream FIFO and other stream sinks in bring-up and loopback paths. With error injection compiled in, it marks selected frames bad via tuser, exercising frame-FIFO drop logic.

## Interface
Parameters:
- DATA_WIDTH, 32, tdata width in bits; multiple of 8
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- LEN_WIDTH, 16, width of frame_len and frame_count
- CNT_WIDTH, 32, width of frames_sent

Ports (reset rst, synchronous, active-low; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- start  in  1  one-cycle command; sampled only in IDLE
- stop  in  1  level; finish current frame then go IDLE
- frame_len  in  LEN_WIDTH  frame length in bytes; 0 treated as 1
- frame_count  in  LEN_WIDTH  frames per run; 0 = continuous until stop
- gap_cycles  in  8  idle cycles (tvalid low) between frames
- err_period  in  8  every Nth frame marked bad; 0 = never (ignored without macro)
- m_axis_tdata  out  DATA_WIDTH  payload
- m_axis_tkeep  out  KEEP_WIDTH  byte enables
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  sink ready
- m_axis_tlast  out  1  last beat of frame
- m_axis_tuser  out  1  bad-frame flag, valid with tlast
- busy  out  1  high from first cycle after accepted start until done
- done  out  1  one-cycle pulse at run completion
- frames_sent  out  CNT_WIDTH  frames completed this run; wraps

## Operation
- States: IDLE, SEND, GAP.
- IDLE: start latches frame_len, frame_count, gap_cycles, err_period; clears frames_sent, frame index, byte offset; -> SEND. start outside IDLE ignored.
- SEND: beat advances only on tvalid && tready. While tvalid high and tready low, tdata/tkeep/tlast/tuser held stable.
- Pattern: byte lane k of a beat = (frame_index + byte_offset + k) mod 256, byte_offset = byte position of lane 0 within frame; frame_index starts 0, 8-bit wrap.
- Beats per frame = ceil(len/KEEP_WIDTH). All beats tkeep all-ones except last: low (len mod KEEP_WIDTH) bits set, all-ones if remainder 0. Unused lanes of last beat driven 0.
- Last beat accepted: frames_sent++, frame_index++. If run complete (frame_count reached, or stop high) -> IDLE with done pulse. Else gap_cycles = 0 -> next frame in SEND with no bubble; else -> GAP.
- GAP: tvalid low for exactly gap_cycles cycles, then SEND. stop high in GAP -> IDLE, done pulse.
- stop never truncates a frame.
- frame_len latched; changes mid-run have no effect.

## Timing
- Reset values: tvalid 0, tdata 0, tkeep 0, tlast 0, tuser 0, busy 0, done 0, frames_sent 0; state IDLE.
- All outputs registered. start at edge N -> tvalid high and busy high after edge N+1 (one cycle latency).
- Back-to-back: with tready held 1 and gap 0, one beat per cycle across frame boundaries, no idle cycle.
- Gap: last beat accepted at edge M -> tvalid low cycles M+1..M+gap, high again after edge M+gap+1.
- done: asserted the cycle after final beat accepted (busy low same cycle); one cycle only.
- Reset mid-frame: all outputs to reset values at that edge; frame truncated (permitted only under reset).
- frames_sent wraps modulo 2^CNT_WIDTH; frame_count counted in its own LEN_WIDTH counter, no wrap issue.

## Configuration
- AXIS_FRAME_GEN_ERR_INJECT_EN defined: when err_period != 0, frame numbers (1-based) divisible by err_period have tuser=1 on last beat; tuser 0 on all other beats.
- Undefined: tuser constant 0, err_period port present but unused, divisor/counter logic absent.

## Structure
- Package axis_frame_gen_pkg: state enum (IDLE, SEND, GAP), KEEP-mask helper function computing last-beat tkeep from len remainder.
- One sub-module: axis_frame_gen_pattern, combinational, (frame_index, byte_offset, tkeep) -> tdata lanes.
- Top holds FSM, counters, output registers.

## Test plan
- DATA_WIDTH=32, len=10, count=1, gap=0, tready=1 -> 3 beats: 0x03020100, 0x07060504, 0x00000908 with tkeep 0xF,0xF,0x3, tlast on beat 3, done 1 cycle later, frames_sent=1.
- len=8, count=3, gap=0, tready=1 -> 6 consecutive tvalid cycles no bubble; frame 1 first beat 0x04030201; frames_sent=3.
- len=4, count=2, gap=5 -> exactly 5 tvalid-low cycles between frames.
- Random tready 50% on len=13 -> tdata/tkeep/tlast stable while stalled; byte stream 0..12 intact, last tkeep 0x1.
- count=0, raise stop mid-frame 4 -> frame 4 completes with tlast, then done, frames_sent=5 (frames 0..4).
- Macro defined, err_period=2, count=4 -> tuser=1 on last beat of frames 2 and 4 only; macro undefined -> tuser always 0. Reset asserted mid-frame -> tvalid 0 next cycle, busy 0.
